// File: rtl/pc_irq_sequencer.sv
// Program counter and vectored, nestable interrupt sequencer for the jacaranda-8 core family.
// Interrupt entry saves {return pc, flag, level} on a small return stack; ret restores it.
module pc_irq_sequencer #(
    parameter int unsigned     PC_W        = 8,
    parameter int unsigned     NUM_IRQ     = 4,
    parameter int unsigned     STACK_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC    = '0
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              jmp_en,
    input  logic                              je_en,
    input  logic                              ret,
    input  logic                              flag_in,
    input  logic [PC_W-1:0]                   jmp_target,
    input  logic                              global_ie,
    input  logic [NUM_IRQ-1:0]                irq_req,
    input  logic [NUM_IRQ-1:0]                irq_en,
    input  logic [NUM_IRQ*PC_W-1:0]           irq_vec,
    output logic [PC_W-1:0]                   pc,
    output logic                              in_isr,
    output logic [$clog2(NUM_IRQ):0]          active_irq,
    output logic [NUM_IRQ-1:0]                irq_ack,
    output logic                              flag_load,
    output logic                              flag_out,
    output logic [$clog2(STACK_DEPTH+1)-1:0]  depth,
    output logic                              underflow_err
);

    localparam int unsigned IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int unsigned AW = $clog2(NUM_IRQ) + 1;
    localparam int unsigned DW = $clog2(STACK_DEPTH + 1);
    localparam int unsigned SW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            flag;
        logic [AW-1:0]   level;
    } frame_t;

    frame_t            stack_q [STACK_DEPTH];

    logic [PC_W-1:0]   pc_q, pc_d;
    logic              in_isr_q, in_isr_d;
    logic [AW-1:0]     active_q, active_d;
    logic [NUM_IRQ-1:0] ack_q, ack_d;
    logic              flag_load_q, flag_load_d;
    logic              flag_out_q, flag_out_d;
    logic [DW-1:0]     depth_q, depth_d;
    logic              uflow_q, uflow_d;

    logic              cand_valid;
    logic [IW-1:0]     cand_idx;
    logic [PC_W-1:0]   cand_vec;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   next_seq;
    logic              accept;
    logic              push_en;
    frame_t            push_frame;
    frame_t            top_frame;
    logic [SW-1:0]     push_idx;
    logic [SW-1:0]     top_idx;

    // Highest-priority (lowest index) enabled request and its vector.
    always_comb begin
        cand_valid = 1'b0;
        cand_idx   = '0;
        cand_vec   = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (irq_req[i] && irq_en[i]) begin
                cand_valid = 1'b1;
                cand_idx   = IW'(i);
                cand_vec   = irq_vec[i*PC_W +: PC_W];
            end
        end
    end

    assign pc_inc   = pc_q + PC_W'(1);
    assign next_seq = (jmp_en || (je_en && flag_in)) ? jmp_target : pc_inc;
    assign push_idx = SW'(depth_q);
    assign top_idx  = SW'(depth_q - DW'(1));
    assign top_frame = stack_q[top_idx];

    // A ret in the same cycle always wins; the request is re-evaluated next cycle.
    assign accept = global_ie && cand_valid && (AW'(cand_idx) < active_q)
                    && (depth_q < DW'(STACK_DEPTH)) && !ret;

    always_comb begin
        pc_d        = next_seq;
        active_d    = active_q;
        ack_d       = '0;
        flag_load_d = 1'b0;
        flag_out_d  = flag_out_q;
        depth_d     = depth_q;
        uflow_d     = uflow_q;
        push_en     = 1'b0;
        push_frame  = '{pc: next_seq, flag: flag_in, level: active_q};

        if (accept) begin
            pc_d     = cand_vec;
            active_d = AW'(cand_idx);
            ack_d    = NUM_IRQ'(1) << cand_idx;
            depth_d  = depth_q + DW'(1);
            push_en  = 1'b1;
        end else if (ret) begin
            if (depth_q != '0) begin
                pc_d        = top_frame.pc;
                active_d    = top_frame.level;
                flag_out_d  = top_frame.flag;
                flag_load_d = 1'b1;
                depth_d     = depth_q - DW'(1);
            end else begin
                pc_d    = pc_inc;
                uflow_d = 1'b1;
            end
        end

        in_isr_d = (depth_d != '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            in_isr_q    <= 1'b0;
            active_q    <= AW'(NUM_IRQ);
            ack_q       <= '0;
            flag_load_q <= 1'b0;
            flag_out_q  <= 1'b0;
            depth_q     <= '0;
            uflow_q     <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            in_isr_q    <= in_isr_d;
            active_q    <= active_d;
            ack_q       <= ack_d;
            flag_load_q <= flag_load_d;
            flag_out_q  <= flag_out_d;
            depth_q     <= depth_d;
            uflow_q     <= uflow_d;
        end
    end

    // Stack contents are meaningless outside depth, so they carry no reset.
    always_ff @(posedge clock) begin
        if (push_en) begin
            stack_q[push_idx] <= push_frame;
        end
    end

    assign pc            = pc_q;
    assign in_isr        = in_isr_q;
    assign active_irq    = active_q;
    assign irq_ack       = ack_q;
    assign flag_load     = flag_load_q;
    assign flag_out      = flag_out_q;
    assign depth         = depth_q;
    assign underflow_err = uflow_q;

endmodule

// File: tb/tb_pc_irq_sequencer.sv
// Directed bench for pc_irq_sequencer, built with a 2-entry return stack so the full-stack case is reachable.
module tb_pc_irq_sequencer;

    localparam int unsigned TB_DEPTH = 2;
    localparam int unsigned DW       = $clog2(TB_DEPTH + 1);
    localparam int unsigned OW       = 8 + 1 + 3 + DW + 4 + 3;

    typedef struct packed {
        logic       jmp;
        logic       je;
        logic       rt;
        logic       fl;
        logic [7:0] tgt;
        logic [3:0] req;
        logic       ie;
        logic [3:0] en;
    } stim_t;

    typedef logic [OW-1:0] obs_t;

    logic          clock;
    logic          reset;
    logic          jmp_en, je_en, ret, flag_in, global_ie;
    logic [7:0]    jmp_target;
    logic [3:0]    irq_req, irq_en;
    logic [31:0]   irq_vec;
    logic [7:0]    pc;
    logic          in_isr;
    logic [2:0]    active_irq;
    logic [3:0]    irq_ack;
    logic          flag_load, flag_out, underflow_err;
    logic [DW-1:0] depth;

    int checks   = 0;
    int failures = 0;

    stim_t st [0:15];
    obs_t  ex [0:15];
    obs_t  obs;

    pc_irq_sequencer #(
        .PC_W        (8),
        .NUM_IRQ     (4),
        .STACK_DEPTH (TB_DEPTH),
        .RESET_PC    (8'h00)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .jmp_en        (jmp_en),
        .je_en         (je_en),
        .ret           (ret),
        .flag_in       (flag_in),
        .jmp_target    (jmp_target),
        .global_ie     (global_ie),
        .irq_req       (irq_req),
        .irq_en        (irq_en),
        .irq_vec       (irq_vec),
        .pc            (pc),
        .in_isr        (in_isr),
        .active_irq    (active_irq),
        .irq_ack       (irq_ack),
        .flag_load     (flag_load),
        .flag_out      (flag_out),
        .depth         (depth),
        .underflow_err (underflow_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Observed vector order: pc, in_isr, active_irq, depth, irq_ack, flag_load, flag_out, underflow_err.
    assign obs = {pc, in_isr, active_irq, depth, irq_ack, flag_load, flag_out, underflow_err};

    function automatic obs_t E(input int p, input int isr, input int act, input int dep,
                               input int ack, input int fl, input int fo, input int uf);
        return {8'(p), 1'(isr), 3'(act), DW'(dep), 4'(ack), 1'(fl), 1'(fo), 1'(uf)};
    endfunction

    function automatic stim_t S(input int jmp, input int je, input int rt, input int fl,
                                input int tgt, input int req, input int ie = 1, input int en = 'hF);
        return {1'(jmp), 1'(je), 1'(rt), 1'(fl), 8'(tgt), 4'(req), 1'(ie), 4'(en)};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        {jmp_en, je_en, ret, flag_in, jmp_target, irq_req} = '0;
        global_ie = 1'b1;
        irq_en    = 4'hF;
        irq_vec   = {8'hE0, 8'h80, 8'hA0, 8'hC0};
        #12;
        checks++;
        if (obs !== E(0, 0, 4, 0, 0, 0, 0, 0)) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", obs, E(0, 0, 4, 0, 0, 0, 0, 0));
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            step();
            checks++;
            if (obs !== E(k % 256, 0, 4, 0, 0, 0, 0, 0)) begin
                failures++;
                $display("FAIL idle_count[%0d] got=%h exp=%h", k, obs, E(k % 256, 0, 4, 0, 0, 0, 0, 0));
            end
        end
    endtask

    task automatic test_jump();
        st[0] = S(1, 0, 0, 0, 'h40, 0); ex[0] = E('h40, 0, 4, 0, 0, 0, 0, 0);
        st[1] = S(0, 1, 0, 0, 'h77, 0); ex[1] = E('h41, 0, 4, 0, 0, 0, 0, 0);
        st[2] = S(0, 1, 0, 1, 'h08, 0); ex[2] = E('h08, 0, 4, 0, 0, 0, 0, 0);
        st[3] = S(1, 1, 0, 0, 'h10, 0); ex[3] = E('h10, 0, 4, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            {jmp_en, je_en, ret, flag_in, jmp_target, irq_req, global_ie, irq_en} = st[k];
            step();
            checks++;
            if (obs !== ex[k]) begin
                failures++;
                $display("FAIL jump[%0d] got=%h exp=%h", k, obs, ex[k]);
            end
        end
    endtask

    task automatic test_irq_basic();
        st[0] = S(0, 0, 0, 1, 0, 'b0100); ex[0] = E('h80, 1, 2, 1, 'b0100, 0, 0, 0);
        st[1] = S(0, 0, 0, 0, 0, 'b0000); ex[1] = E('h81, 1, 2, 1, 0, 0, 0, 0);
        st[2] = S(0, 0, 1, 0, 0, 'b0000); ex[2] = E('h11, 0, 4, 0, 0, 1, 1, 0);
        st[3] = S(0, 0, 0, 0, 0, 'b0000); ex[3] = E('h12, 0, 4, 0, 0, 0, 1, 0);
        for (int k = 0; k < 4; k++) begin
            {jmp_en, je_en, ret, flag_in, jmp_target, irq_req, global_ie, irq_en} = st[k];
            step();
            checks++;
            if (obs !== ex[k]) begin
                failures++;
                $display("FAIL irq_basic[%0d] got=%h exp=%h", k, obs, ex[k]);
            end
        end
    endtask

    task automatic test_nesting();
        st[0] = S(0, 0, 0, 0, 0,     'b0100); ex[0] = E('h80, 1, 2, 1, 'b0100, 0, 1, 0);
        st[1] = S(0, 0, 0, 0, 0,     'b1000); ex[1] = E('h81, 1, 2, 1, 0, 0, 1, 0);
        st[2] = S(1, 0, 0, 1, 'h90,  'b1001); ex[2] = E('hC0, 1, 0, 2, 'b0001, 0, 1, 0);
        st[3] = S(0, 0, 0, 0, 0,     'b1000); ex[3] = E('hC1, 1, 0, 2, 0, 0, 1, 0);
        st[4] = S(0, 0, 1, 0, 0,     'b1000); ex[4] = E('h90, 1, 2, 1, 0, 1, 1, 0);
        st[5] = S(0, 0, 1, 0, 0,     'b0000); ex[5] = E('h13, 0, 4, 0, 0, 1, 0, 0);
        st[6] = S(0, 0, 0, 0, 0,     'b0000); ex[6] = E('h14, 0, 4, 0, 0, 0, 0, 0);
        for (int k = 0; k < 7; k++) begin
            {jmp_en, je_en, ret, flag_in, jmp_target, irq_req, global_ie, irq_en} = st[k];
            step();
            checks++;
            if (obs !== ex[k]) begin
                failures++;
                $display("FAIL nesting[%0d] got=%h exp=%h", k, obs, ex[k]);
            end
        end
    endtask

    task automatic test_stack_full();
        st[0] = S(0, 0, 0, 0, 0, 'b1000); ex[0] = E('hE0, 1, 3, 1, 'b1000, 0, 0, 0);
        st[1] = S(0, 0, 0, 0, 0, 'b0100); ex[1] = E('h80, 1, 2, 2, 'b0100, 0, 0, 0);
        st[2] = S(0, 0, 0, 0, 0, 'b0001); ex[2] = E('h81, 1, 2, 2, 0, 0, 0, 0);
        st[3] = S(0, 0, 0, 0, 0, 'b0001); ex[3] = E('h82, 1, 2, 2, 0, 0, 0, 0);
        st[4] = S(0, 0, 1, 0, 0, 'b0001); ex[4] = E('hE1, 1, 3, 1, 0, 1, 0, 0);
        st[5] = S(0, 0, 0, 1, 0, 'b0001); ex[5] = E('hC0, 1, 0, 2, 'b0001, 0, 0, 0);
        st[6] = S(0, 0, 1, 0, 0, 'b0000); ex[6] = E('hE2, 1, 3, 1, 0, 1, 1, 0);
        st[7] = S(0, 0, 1, 0, 0, 'b0000); ex[7] = E('h15, 0, 4, 0, 0, 1, 0, 0);
        st[8] = S(0, 0, 0, 0, 0, 'b0000); ex[8] = E('h16, 0, 4, 0, 0, 0, 0, 0);
        for (int k = 0; k < 9; k++) begin
            {jmp_en, je_en, ret, flag_in, jmp_target, irq_req, global_ie, irq_en} = st[k];
            step();
            checks++;
            if (obs !== ex[k]) begin
                failures++;
                $display("FAIL stack_full[%0d] got=%h exp=%h", k, obs, ex[k]);
            end
        end
    endtask

    task automatic test_underflow();
        st[0] = S(0, 0, 1, 0, 0,    0); ex[0] = E('h17, 0, 4, 0, 0, 0, 0, 1);
        st[1] = S(1, 0, 1, 0, 'h50, 0); ex[1] = E('h18, 0, 4, 0, 0, 0, 0, 1);
        st[2] = S(1, 0, 0, 0, 'h50, 0); ex[2] = E('h50, 0, 4, 0, 0, 0, 0, 1);
        st[3] = S(0, 0, 0, 0, 0,    0); ex[3] = E('h51, 0, 4, 0, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) begin
            {jmp_en, je_en, ret, flag_in, jmp_target, irq_req, global_ie, irq_en} = st[k];
            step();
            checks++;
            if (obs !== ex[k]) begin
                failures++;
                $display("FAIL underflow[%0d] got=%h exp=%h", k, obs, ex[k]);
            end
        end
    endtask

    task automatic test_gating_and_reset();
        st[0] = S(0, 0, 0, 0, 0, 'b0001, 0, 'hF);    ex[0] = E('h52, 0, 4, 0, 0, 0, 0, 1);
        st[1] = S(0, 0, 0, 0, 0, 'b0011, 1, 'b1100); ex[1] = E('h53, 0, 4, 0, 0, 0, 0, 1);
        st[2] = S(0, 0, 0, 0, 0, 'b0011, 1, 'b1110); ex[2] = E('hA0, 1, 1, 1, 'b0010, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            {jmp_en, je_en, ret, flag_in, jmp_target, irq_req, global_ie, irq_en} = st[k];
            step();
            checks++;
            if (obs !== ex[k]) begin
                failures++;
                $display("FAIL gating[%0d] got=%h exp=%h", k, obs, ex[k]);
            end
        end
        irq_req = '0;
        irq_en  = 4'hF;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (obs !== E(0, 0, 4, 0, 0, 0, 0, 0)) begin
            failures++;
            $display("FAIL async_reset got=%h exp=%h", obs, E(0, 0, 4, 0, 0, 0, 0, 0));
        end
        step();
        reset = 1'b0;
        step();
        checks++;
        if (obs !== E(1, 0, 4, 0, 0, 0, 0, 0)) begin
            failures++;
            $display("FAIL post_reset got=%h exp=%h", obs, E(1, 0, 4, 0, 0, 0, 0, 0));
        end
    endtask

    initial begin
        test_reset();
        test_jump();
        test_irq_basic();
        test_nesting();
        test_stack_full();
        test_underflow();
        test_gating_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
